dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory. It sits between the CPU MEM stage and the UART load/DMA engine, granting at most one access per cycle and steering the granted requester onto the memory port. It returns read data one cycle later to the correct owner. When the CPU MEM stage loses arbitration, the block raises a stall that the hazard unit uses to freeze the pipeline.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_pick.sv | 51 +++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-owner tag, lock FSM states
// and the default lock length.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DMA_LOCK = 1'b1
  } state_e;

  localparam int MAX_LOCK_DEF = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant picker: one-hot CPU/DMA grant from requests, lock state
// and round-robin pointer (pointer honoured only when DMEM_ARB_RR_EN is defined).
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_DEF,
  parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
  input  logic             cpu_req_i,
  input  logic             dma_req_i,
  input  logic             dma_lock_i,
  input  state_e           state_i,
  input  logic [CNT_W-1:0] lock_cnt_i,
  input  logic             ptr_i,
  output logic             cpu_gnt_o,
  output logic             dma_gnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  // A lock only counts while DMA keeps both req and lock up; otherwise IDLE rules apply.
  logic lock_live;
  assign lock_live = (state_i == ST_DMA_LOCK) && dma_req_i && dma_lock_i;

`ifndef DMEM_ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

  always_comb begin
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    if (cpu_req_i && dma_req_i) begin
      if (lock_live) begin
        if (lock_cnt_i < MAX_CNT) dma_gnt_o = 1'b1;
        else                      cpu_gnt_o = 1'b1;
      end else begin
`ifdef DMEM_ARB_RR_EN
        dma_gnt_o = ptr_i;
        cpu_gnt_o = ~ptr_i;
`else
        cpu_gnt_o = 1'b1;
`endif
      end
    end else begin
      cpu_gnt_o = cpu_req_i;
      dma_gnt_o = dma_req_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-port data memory with DMA burst lock and
// one-cycle read return. DMEM_ARB_RR_EN selects round-robin contention, else CPU priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            own_q, own_d;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              ptr;
  logic              cpu_pick, dma_pick;

  dmem_arb_pick #(
    .MAX_LOCK (MAX_LOCK),
    .CNT_W    (CNT_W)
  ) u_pick (
    .cpu_req_i  (cpu_req),
    .dma_req_i  (dma_req),
    .dma_lock_i (dma_lock),
    .state_i    (state_q),
    .lock_cnt_i (cnt_q),
    .ptr_i      (ptr),
    .cpu_gnt_o  (cpu_pick),
    .dma_gnt_o  (dma_pick)
  );

  // Outputs are forced quiet while reset is held, including a pending read return.
  assign cpu_gnt   = cpu_pick & ~reset;
  assign dma_gnt   = dma_pick & ~reset;
  assign cpu_stall = cpu_req & ~cpu_gnt & ~reset;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_rd    = ~cpu_wr;
      mem_wr    = cpu_wr;
      mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_rd    = ~dma_wr;
      mem_wr    = dma_wr;
      mem_addr  = {dma_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!(dma_req && dma_lock) || cpu_gnt) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (dma_gnt) begin
      state_d = ST_DMA_LOCK;
      if (state_q == ST_IDLE)    cnt_d = CNT_W'(1);
      else if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    own_d = OWN_NONE;
    if (cpu_gnt && !cpu_wr)      own_d = OWN_CPU;
    else if (dma_gnt && !dma_wr) own_d = OWN_DMA;
  end

  assign cpu_rvalid = (own_q == OWN_CPU) & ~reset;
  assign dma_rvalid = (own_q == OWN_DMA) & ~reset;
  assign cpu_rdata  = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_rdata_q);
  assign dma_rdata  = reset ? '0 : (dma_rvalid ? mem_rdata : dma_rdata_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      own_q       <= OWN_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      cpu_rdata_q <= cpu_rdata;
      dma_rdata_q <= dma_rdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;

  // ptr_q=1 means DMA is preferred on the next contention.
  always_comb begin
    ptr_d = ptr_q;
    if (cpu_gnt)      ptr_d = 1'b1;
    else if (dma_gnt) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_LOCK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, dma_req, dma_wr, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, described in transaction terms.
  bit          m_locked     = 1'b0;  // DMA currently holds a burst lock
  int          m_lock_n     = 0;     // DMA grants taken in the current lock
  bit          m_prefer_dma = 1'b0;  // last grant went to the CPU
  int          m_pend       = 0;     // read returning next cycle: 0 none, 1 cpu, 2 dma
  logic [31:0] m_cpu_hold   = '0;
  logic [31:0] m_dma_hold   = '0;
  bit          m_ec = 1'b0, m_ed = 1'b0;

  always @(negedge clk) begin
    bit          ec, ed, e_crv, e_drv;
    logic [31:0] e_addr, e_wdata, e_crd, e_drd;
    ec = 1'b0;
    ed = 1'b0;
    if (!reset) begin
      if (cpu_req && dma_req) begin
        if (m_locked && dma_lock) begin
          if (m_lock_n < MAX_LOCK) ed = 1'b1;
          else                     ec = 1'b1;
        end else begin
`ifdef DMEM_ARB_RR_EN
          ed = m_prefer_dma;
          ec = !m_prefer_dma;
`else
          ec = 1'b1;
`endif
        end
      end else begin
        ec = cpu_req;
        ed = dma_req;
      end
    end
    e_addr  = ec ? (cpu_addr & ~32'h3) : ed ? (dma_addr & ~32'h3) : 32'h0;
    e_wdata = ec ? cpu_wdata : ed ? dma_wdata : 32'h0;
    e_crv   = !reset && (m_pend == 1);
    e_drv   = !reset && (m_pend == 2);
    e_crd   = reset ? 32'h0 : (e_crv ? mem_rdata : m_cpu_hold);
    e_drd   = reset ? 32'h0 : (e_drv ? mem_rdata : m_dma_hold);

    chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    chk("dma_gnt", 32'(dma_gnt), 32'(ed));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !ec && !reset));
    chk("mem_rd", 32'(mem_rd), 32'((ec && !cpu_wr) || (ed && !dma_wr)));
    chk("mem_wr", 32'(mem_wr), 32'((ec && cpu_wr) || (ed && dma_wr)));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("dma_rdata", dma_rdata, e_drd);

    m_ec = ec;
    m_ed = ed;
    if (reset) begin
      m_locked = 1'b0; m_lock_n = 0; m_prefer_dma = 1'b0;
      m_pend = 0; m_cpu_hold = '0; m_dma_hold = '0;
    end else begin
      m_cpu_hold = e_crd;
      m_dma_hold = e_drd;
      m_pend = (ec && !cpu_wr) ? 1 : (ed && !dma_wr) ? 2 : 0;
      if (ec) m_prefer_dma = 1'b1;
      if (ed) m_prefer_dma = 1'b0;
      if (dma_req && dma_lock && ed) begin
        if (!m_locked) m_lock_n = 1;
        else if (m_lock_n < MAX_LOCK) m_lock_n++;
        m_locked = 1'b1;
      end else begin
        m_locked = 1'b0;
        m_lock_n = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cpu_req = 0; cpu_wr = 0; dma_req = 0; dma_wr = 0; dma_lock = 0;
  endtask

  initial begin
    bit rr_exp [4];
    reset = 1; idle_all();
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0; mem_rdata = '0;
    cyc();
    cpu_req = 1; dma_req = 1;
    #3;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    cyc();
    reset = 0; idle_all();
    cyc();

    // Single CPU read
    cpu_req = 1; cpu_addr = 32'h100;
    #3; chk("t1_gnt", 32'(cpu_gnt), 32'd1); chk("t1_addr", mem_addr, 32'h100);
    cyc();
    cpu_req = 0; mem_rdata = 32'hDEADBEEF;
    #3; chk("t1_rvalid", 32'(cpu_rvalid), 32'd1); chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_dma_rvalid", 32'(dma_rvalid), 32'd0);
    cyc();
    mem_rdata = '0;

    // Lone DMA read, then 4 cycles of contention
    dma_req = 1; dma_addr = 32'h300;
    #3; chk("t2_dma_alone", 32'(dma_gnt), 32'd1);
    cyc();
`ifdef DMEM_ARB_RR_EN
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    rr_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    cpu_req = 1; cpu_addr = 32'h104;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("t2_cpu_gnt", 32'(cpu_gnt), 32'(rr_exp[i]));
      chk("t2_stall", 32'(cpu_stall), 32'(!rr_exp[i]));
      cyc();
    end
    idle_all();
    cyc();

    // Locked DMA burst against a waiting CPU
    dma_req = 1; dma_lock = 1;
    #3; chk("t3_dma0", 32'(dma_gnt), 32'd1);
    cyc();
    cpu_req = 1;
    for (int i = 1; i <= 4; i++) begin
      #3;
      chk("t3_dma_gnt", 32'(dma_gnt), 32'(i < 4));
      chk("t3_cpu_gnt", 32'(cpu_gnt), 32'(i == 4));
      cyc();
    end
    idle_all();
    cyc();

    // Lock dropped after two grants
    dma_req = 1; dma_lock = 1;
    cyc();
    cpu_req = 1;
    #3; chk("t4_dma_gnt", 32'(dma_gnt), 32'd1);
    cyc();
    dma_lock = 0;
    #3; chk("t4_cpu_gnt", 32'(cpu_gnt), 32'd1); chk("t4_dma_off", 32'(dma_gnt), 32'd0);
    cyc();
    idle_all();
    cyc();

    // DMA write then CPU read of the same word
    dma_req = 1; dma_wr = 1; dma_addr = 32'h200; dma_wdata = 32'h55;
    #3; chk("t5_wr", 32'(mem_wr), 32'd1); chk("t5_waddr", mem_addr, 32'h200);
    chk("t5_wdata", mem_wdata, 32'h55);
    cyc();
    dma_req = 0; dma_wr = 0; cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h200;
    #3; chk("t5_rd", 32'(mem_rd), 32'd1); chk("t5_raddr", mem_addr, 32'h200);
    cyc();
    cpu_req = 0; mem_rdata = 32'h55;
    #3; chk("t5_rvalid", 32'(cpu_rvalid), 32'd1); chk("t5_rdata", cpu_rdata, 32'h55);
    cyc();

    // Reset while a read is in flight
    cpu_req = 1; cpu_addr = 32'h10; mem_rdata = 32'h1234;
    cyc();
    cpu_req = 0; reset = 1;
    #3; chk("t6_rvalid", 32'(cpu_rvalid), 32'd0); chk("t6_rdata", cpu_rdata, 32'd0);
    cyc();
    reset = 0; cpu_req = 1; dma_req = 1;
    #3; chk("t6_cpu_first", 32'(cpu_gnt), 32'd1); chk("t6_dma_wait", 32'(dma_gnt), 32'd0);
    cyc();
    idle_all();

    // Random traffic with the hold-until-granted handshake
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!(cpu_req && !m_ec) || $urandom_range(0, 9) == 0) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_wr    = 1'($urandom_range(0, 1));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (!(dma_req && !m_ed) || $urandom_range(0, 9) == 0) begin
        dma_req   = ($urandom_range(0, 2) != 0);
        dma_wr    = 1'($urandom_range(0, 1));
        dma_addr  = $urandom;
        dma_wdata = $urandom;
      end
      if ($urandom_range(0, 5) == 0) dma_lock = !dma_lock;
      mem_rdata = $urandom;
      cyc();
    end

    reset = 0; idle_all();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
